// File: rtl/ibex_fetch_align_fifo.sv
// ibex_fetch_align_fifo
//   Small prefetch FIFO that also aligns instructions: accepts word-aligned
//   fetch responses and presents one complete instruction (compressed or not)
//   at a half-word aligned address to the decoder.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i, in_addr_i     flush all entries and load a new fetch address
//   in_valid_i/in_ready_o  fetch response handshake (ready = room for NUM_REQS)
//   in_rdata_i, in_err_i   response word and its bus error flag
//   out_valid_o/out_ready_i instruction handshake
//   out_addr_o, out_rdata_o instruction address and bits (compressed in [15:0])
//   out_err_o              instruction carries a fetch error
//   out_err_plus2_o        error comes only from the upper half of an unaligned
//                          32-bit instruction
//   occupancy_o            number of valid FIFO entries
module ibex_fetch_align_fifo #(
   parameter int unsigned NUM_REQS      = 2,
   parameter int unsigned COMPRESSED_EN = 1,
   localparam int unsigned DEPTH = NUM_REQS + 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      in_addr_i,
   input  logic [31:0]      in_rdata_i,
   input  logic             in_err_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [31:0]      out_addr_o,
   output logic [31:0]      out_rdata_o,
   output logic             out_err_o,
   output logic             out_err_plus2_o,
   output logic [CNT_W-1:0] occupancy_o
);

   logic [31:0]      rdata_q [DEPTH];
   logic [31:0]      rdata_d [DEPTH];
   logic             err_q   [DEPTH];
   logic             err_d   [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:1]      addr_q, addr_d;

   logic [31:0]      head_data;
   logic             head_err, head_valid;
   logic [15:0]      next_lo;
   logic             next_err, next_valid;
   logic             unaligned, instr_compr, fire, pop;

   // Staging view: current entries plus the incoming word at the lowest free
   // slot. One extra slot lets a push into a full FIFO survive a same-cycle pop.
   logic [31:0]      stg_data  [DEPTH+1];
   logic             stg_err   [DEPTH+1];
   logic [DEPTH:0]   stg_valid;

   logic             unused_addr0;
   assign unused_addr0 = in_addr_i[0];

   // Head and next word, bypassing the FIFO when the entries are not there yet
   always_comb begin
      head_data  = valid_q[0] ? rdata_q[0] : in_rdata_i;
      head_err   = valid_q[0] ? err_q[0]   : in_err_i;
      head_valid = valid_q[0] | in_valid_i;
      next_lo    = valid_q[1] ? rdata_q[1][15:0] : in_rdata_i[15:0];
      next_err   = valid_q[1] ? err_q[1]         : in_err_i;
      next_valid = valid_q[1] | (valid_q[0] & in_valid_i);
   end

   always_comb begin
      unaligned   = (COMPRESSED_EN != 0) & addr_q[1];
      instr_compr = 1'b0;
      if (COMPRESSED_EN != 0) begin
         instr_compr = unaligned ? (head_data[17:16] != 2'b11)
                                 : (head_data[1:0]   != 2'b11);
      end

      out_rdata_o     = head_data;
      out_err_o       = head_err;
      out_err_plus2_o = 1'b0;
      out_valid_o     = head_valid;
      if (unaligned) begin
         if (instr_compr) begin
            out_rdata_o = {16'h0000, head_data[31:16]};
         end else begin
            out_rdata_o     = {next_lo, head_data[31:16]};
            out_valid_o     = head_valid & next_valid;
            out_err_o       = head_err | next_err;
            out_err_plus2_o = next_err & ~head_err;
         end
      end

      fire = out_valid_o & out_ready_i & ~clear_i;
      // An aligned compressed instruction leaves its upper half in the head.
      pop  = fire & (unaligned | ~instr_compr);
   end

   always_comb begin
      for (int i = 0; i <= DEPTH; i++) begin
         stg_data[i]  = in_rdata_i;
         stg_err[i]   = in_err_i;
         stg_valid[i] = 1'b0;
         if (i < DEPTH) begin
            stg_data[i]  = rdata_q[i];
            stg_err[i]   = err_q[i];
            stg_valid[i] = valid_q[i];
         end
         if (in_valid_i && (cnt_q == CNT_W'(i))) begin
            stg_data[i]  = in_rdata_i;
            stg_err[i]   = in_err_i;
            stg_valid[i] = 1'b1;
         end
      end

      for (int i = 0; i < DEPTH; i++) begin
         rdata_d[i] = pop ? stg_data[i+1]  : stg_data[i];
         err_d[i]   = pop ? stg_err[i+1]   : stg_err[i];
         valid_d[i] = pop ? stg_valid[i+1] : stg_valid[i];
      end
      if (clear_i) begin
         valid_d = '0;
      end

      cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt_d = cnt_d + CNT_W'(valid_d[i]);
      end
   end

   always_comb begin
      addr_d = addr_q;
      if (clear_i) begin
         addr_d = in_addr_i[31:1];
         if (COMPRESSED_EN == 0) begin
            addr_d[1] = 1'b0;
         end
      end else if (fire) begin
         addr_d = addr_q + (instr_compr ? 31'd1 : 31'd2);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < DEPTH; i++) begin
         rdata_q[i] <= rdata_d[i];
         err_q[i]   <= err_d[i];
      end
      addr_q <= addr_d;
   end

   assign in_ready_o  = (cnt_q <= CNT_W'(DEPTH - NUM_REQS));
   assign occupancy_o = cnt_q;
   assign out_addr_o  = {addr_q, 1'b0};

   // Upstream must never deliver a word with nowhere to put it.
   a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
      !(in_valid_i && valid_q[DEPTH-1] && !pop));

endmodule

// File: tb/tb_ibex_fetch_align_fifo.sv
module tb_ibex_fetch_align_fifo;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        clear_i, in_valid_i, out_ready_i;
   logic        clear0, in_valid0, out_ready0;
   logic [31:0] in_addr_i, in_rdata_i;
   logic        in_err_i;

   logic        in_ready_o, out_valid_o, out_err_o, out_err_plus2_o;
   logic [31:0] out_addr_o, out_rdata_o;
   logic [1:0]  occupancy_o;

   logic        in_ready0, out_valid0, out_err0, out_err_plus20;
   logic [31:0] out_addr0, out_rdata0;
   logic [1:0]  occupancy0;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   ibex_fetch_align_fifo #(.NUM_REQS(2), .COMPRESSED_EN(1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_addr_i(in_addr_i),
      .in_rdata_i(in_rdata_i), .in_err_i(in_err_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_addr_o(out_addr_o), .out_rdata_o(out_rdata_o),
      .out_err_o(out_err_o), .out_err_plus2_o(out_err_plus2_o),
      .occupancy_o(occupancy_o));

   ibex_fetch_align_fifo #(.NUM_REQS(2), .COMPRESSED_EN(0)) dut0 (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear0),
      .in_valid_i(in_valid0), .in_ready_o(in_ready0), .in_addr_i(in_addr_i),
      .in_rdata_i(in_rdata_i), .in_err_i(in_err_i),
      .out_valid_o(out_valid0), .out_ready_i(out_ready0),
      .out_addr_o(out_addr0), .out_rdata_o(out_rdata0),
      .out_err_o(out_err0), .out_err_plus2_o(out_err_plus20),
      .occupancy_o(occupancy0));

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic idle();
      clear_i = 0; in_valid_i = 0; out_ready_i = 0;
      clear0 = 0; in_valid0 = 0; out_ready0 = 0;
      in_err_i = 0; in_rdata_i = 32'h0;
   endtask

   task automatic do_clear(input logic [31:0] a);
      idle();
      clear_i = 1; in_addr_i = a;
      tick();
      clear_i = 0;
   endtask

   task automatic test_reset();
      rst_ni = 0; idle(); in_addr_i = 32'h0;
      #2;
      total++; if (occupancy_o !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occupancy_o); end
      total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready_o); end
      total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid_o); end
      in_valid_i = 1; in_rdata_i = 32'h0000_0000;
      #1;
      total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL reset_bypass got=%b want=1", out_valid_o); end
      idle();
      tick();
      rst_ni = 1;
      tick();
   endtask

   task automatic test_bypass();
      do_clear(32'h0000_0100);
      in_valid_i = 1; in_rdata_i = 32'h0000_0013; out_ready_i = 1;
      #1;
      total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL byp_valid got=%b want=1", out_valid_o); end
      total++; if (out_addr_o !== 32'h100) begin bad++; $display("FAIL byp_addr got=%h want=00000100", out_addr_o); end
      total++; if (out_rdata_o !== 32'h13) begin bad++; $display("FAIL byp_rdata got=%h want=00000013", out_rdata_o); end
      tick(); idle();
      #1;
      total++; if (occupancy_o !== 2'd0) begin bad++; $display("FAIL byp_occ got=%0d want=0", occupancy_o); end
      total++; if (out_addr_o !== 32'h104) begin bad++; $display("FAIL byp_next_addr got=%h want=00000104", out_addr_o); end
   endtask

   task automatic test_unaligned_compressed();
      do_clear(32'h0000_0102);
      in_valid_i = 1; in_rdata_i = 32'h0001_4501; out_ready_i = 1;
      #1;
      total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL uc_valid got=%b want=1", out_valid_o); end
      total++; if (out_rdata_o[15:0] !== 16'h0001) begin bad++; $display("FAIL uc_rdata got=%h want=0001", out_rdata_o[15:0]); end
      total++; if (out_addr_o !== 32'h102) begin bad++; $display("FAIL uc_addr got=%h want=00000102", out_addr_o); end
      tick();
      total++; if (occupancy_o !== 2'd0) begin bad++; $display("FAIL uc_pop_occ got=%0d want=0", occupancy_o); end
      total++; if (out_addr_o !== 32'h104) begin bad++; $display("FAIL uc_addr2 got=%h want=00000104", out_addr_o); end
      in_rdata_i = 32'h0000_0000; out_ready_i = 0;
      #1;
      total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL uc_second_valid got=%b want=1", out_valid_o); end
      tick();
      in_valid_i = 0; out_ready_i = 1;
      #1;
      total++; if (occupancy_o !== 2'd1) begin bad++; $display("FAIL uc_store_occ got=%0d want=1", occupancy_o); end
      tick();
      total++; if (occupancy_o !== 2'd1) begin bad++; $display("FAIL ac_nopop_occ got=%0d want=1", occupancy_o); end
      total++; if (out_addr_o !== 32'h106) begin bad++; $display("FAIL ac_addr got=%h want=00000106", out_addr_o); end
      tick();
      total++; if (occupancy_o !== 2'd0) begin bad++; $display("FAIL uc_upper_pop_occ got=%0d want=0", occupancy_o); end
      total++; if (out_addr_o !== 32'h108) begin bad++; $display("FAIL uc_upper_addr got=%h want=00000108", out_addr_o); end
      idle();
   endtask

   task automatic test_err_plus2();
      do_clear(32'h0000_0102);
      in_valid_i = 1; in_rdata_i = 32'h0513_0000; in_err_i = 0;
      #1;
      total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL ep2_half_valid got=%b want=0", out_valid_o); end
      tick();
      in_rdata_i = 32'h0000_00AB; in_err_i = 1; out_ready_i = 1;
      #1;
      total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL ep2_valid got=%b want=1", out_valid_o); end
      total++; if (out_rdata_o !== 32'h00AB_0513) begin bad++; $display("FAIL ep2_rdata got=%h want=00ab0513", out_rdata_o); end
      total++; if (out_err_o !== 1'b1) begin bad++; $display("FAIL ep2_err got=%b want=1", out_err_o); end
      total++; if (out_err_plus2_o !== 1'b1) begin bad++; $display("FAIL ep2_plus2 got=%b want=1", out_err_plus2_o); end
      tick();
      in_valid_i = 0; in_err_i = 0; out_ready_i = 0;
      #1;
      total++; if (occupancy_o !== 2'd1) begin bad++; $display("FAIL ep2_occ got=%0d want=1", occupancy_o); end
      total++; if (out_addr_o !== 32'h106) begin bad++; $display("FAIL ep2_addr got=%h want=00000106", out_addr_o); end
      total++; if (out_err_o !== 1'b1 || out_err_plus2_o !== 1'b0) begin bad++; $display("FAIL ep2_head_err got=%b%b want=10", out_err_o, out_err_plus2_o); end
      idle();
   endtask

   task automatic test_fill_and_clear();
      logic [31:0] words [3];
      logic [1:0]  exp_rdy;
      words[0] = 32'h1111_1113; words[1] = 32'h2222_2223; words[2] = 32'h3333_3333;
      do_clear(32'h0000_0000);
      #1;
      total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL fill_rdy0 got=%b want=1", in_ready_o); end
      for (int i = 0; i < 3; i++) begin
         in_valid_i = 1; in_rdata_i = words[i];
         tick();
         in_valid_i = 0;
         #1;
         exp_rdy = (i == 0) ? 2'd1 : 2'd0;
         total++; if (occupancy_o !== 2'(i + 1)) begin bad++; $display("FAIL fill_occ%0d got=%0d want=%0d", i, occupancy_o, i + 1); end
         total++; if (in_ready_o !== exp_rdy[0]) begin bad++; $display("FAIL fill_rdy%0d got=%b want=%b", i + 1, in_ready_o, exp_rdy[0]); end
      end
      total++; if (out_rdata_o !== 32'h1111_1113) begin bad++; $display("FAIL fill_head got=%h want=11111113", out_rdata_o); end
      in_valid_i = 1; in_rdata_i = 32'h4444_4443; out_ready_i = 1;
      tick();
      in_valid_i = 0; out_ready_i = 0;
      #1;
      total++; if (occupancy_o !== 2'd3) begin bad++; $display("FAIL fullpush_occ got=%0d want=3", occupancy_o); end
      total++; if (out_rdata_o !== 32'h2222_2223) begin bad++; $display("FAIL fullpush_head got=%h want=22222223", out_rdata_o); end
      total++; if (out_addr_o !== 32'h4) begin bad++; $display("FAIL fullpush_addr got=%h want=00000004", out_addr_o); end
      clear_i = 1; in_addr_i = 32'h0000_0400; in_valid_i = 1; in_rdata_i = 32'h5555_5553; out_ready_i = 1;
      tick();
      idle();
      #1;
      total++; if (occupancy_o !== 2'd0) begin bad++; $display("FAIL clr_occ got=%0d want=0", occupancy_o); end
      total++; if (out_addr_o !== 32'h400) begin bad++; $display("FAIL clr_addr got=%h want=00000400", out_addr_o); end
      total++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin bad++; $display("FAIL clr_flags got=%b%b want=01", out_valid_o, in_ready_o); end
   endtask

   task automatic test_wrap();
      do_clear(32'hFFFF_FFFC);
      in_valid_i = 1; in_rdata_i = 32'h0000_0013; out_ready_i = 1;
      tick();
      idle();
      #1;
      total++; if (out_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h want=00000000", out_addr_o); end
   endtask

   task automatic test_async_reset();
      do_clear(32'h0000_0000);
      in_valid_i = 1; in_rdata_i = 32'h0000_0013;
      tick(); tick();
      in_valid_i = 0;
      #1;
      total++; if (occupancy_o !== 2'd2) begin bad++; $display("FAIL ar_pre_occ got=%0d want=2", occupancy_o); end
      rst_ni = 0;
      #1;
      total++; if (occupancy_o !== 2'd0) begin bad++; $display("FAIL ar_occ got=%0d want=0", occupancy_o); end
      total++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin bad++; $display("FAIL ar_flags got=%b%b want=01", out_valid_o, in_ready_o); end
      #1 rst_ni = 1;
      tick();
   endtask

   task automatic test_no_compressed();
      idle();
      clear0 = 1; in_addr_i = 32'h0000_0202;
      tick();
      clear0 = 0;
      #1;
      total++; if (out_addr0 !== 32'h200) begin bad++; $display("FAIL nc_load_addr got=%h want=00000200", out_addr0); end
      in_valid0 = 1; in_rdata_i = 32'h0000_0001; out_ready0 = 1;
      #1;
      total++; if (out_valid0 !== 1'b1 || out_rdata0 !== 32'h1) begin bad++; $display("FAIL nc_out got=%b/%h want=1/00000001", out_valid0, out_rdata0); end
      tick();
      total++; if (out_addr0 !== 32'h204 || occupancy0 !== 2'd0) begin bad++; $display("FAIL nc_step1 got=%h/%0d want=00000204/0", out_addr0, occupancy0); end
      in_rdata_i = 32'h0000_0003; in_err_i = 1;
      #1;
      total++; if (out_err0 !== 1'b1 || out_err_plus20 !== 1'b0) begin bad++; $display("FAIL nc_err got=%b%b want=10", out_err0, out_err_plus20); end
      tick();
      total++; if (out_addr0 !== 32'h208) begin bad++; $display("FAIL nc_step2 got=%h want=00000208", out_addr0); end
      idle();
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_unaligned_compressed();
      test_err_plus2();
      test_fill_and_clear();
      test_wrap();
      test_async_reset();
      test_no_compressed();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
